// File: rtl/y86_execute_cc.sv
// Y86-64 execute stage: valE ALU, ZF/SF/OF condition codes, Cnd, registered valid/ready output.
// Optional Y86_EXEC_HALT_EN: an accepted halt latches a sticky flag that blocks further input until rst.
module sub64x1 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] d
);
  assign d = a - b;
endmodule

module y86_execute_cc #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic         out_cnd,
  output logic         out_err,
  output logic [2:0]   cc
);
  localparam logic [3:0] I_HALT  = 4'h0, I_NOP  = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ  = 4'h6, I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8, I_RET  = 4'h9, I_PUSH  = 4'hA, I_POP   = 4'hB;
  localparam logic signed [W-1:0] STEP = W'(STACK_STEP);

  // Signed overflow: operands share a sign that the result does not.
  function automatic logic add_of(input logic signed [W-1:0] a, b, e);
    return (a[W-1] == b[W-1]) && (e[W-1] != b[W-1]);
  endfunction

  // For e = b - a the operand signs must differ for overflow to be possible.
  function automatic logic sub_of(input logic signed [W-1:0] a, b, e);
    return (a[W-1] != b[W-1]) && (e[W-1] != b[W-1]);
  endfunction

  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] ccv);
    logic zf, lt;
    zf = ccv[2];
    lt = ccv[1] ^ ccv[0];
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt | zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  logic signed [W-1:0] a_s, b_s, sum_ba, diff_ba, alu_e, vale;
  logic                of_n, err, cnd, accept, cc_upd;

  assign a_s    = valA;
  assign b_s    = valB;
  assign sum_ba = b_s + a_s;

  sub64x1 u_sub (.a(valB), .b(valA), .d(diff_ba));

  always_comb begin
    err = (icode > I_POP) || (icode == I_OPQ && ifun > 4'd3) ||
          ((icode == I_RRMOV || icode == I_JXX) && ifun > 4'd6);
    alu_e = '0;
    of_n  = 1'b0;
    case (ifun[1:0])
      2'd0: begin alu_e = sum_ba;  of_n = add_of(a_s, b_s, sum_ba);  end
      2'd1: begin alu_e = diff_ba; of_n = sub_of(a_s, b_s, diff_ba); end
      2'd2: alu_e = b_s & a_s;
      default: alu_e = b_s ^ a_s;
    endcase
    vale = '0;
    case (icode)
      I_RRMOV:          vale = a_s;
      I_IRMOV:          vale = signed'(valC);
      I_RMMOV, I_MRMOV: vale = b_s + signed'(valC);
      I_OPQ:            vale = alu_e;
      I_CALL, I_PUSH:   vale = b_s - STEP;
      I_RET, I_POP:     vale = b_s + STEP;
      I_HALT, I_NOP, I_JXX: vale = '0;
      default:          vale = '0;
    endcase
    cnd = 1'b0;
    if ((icode == I_RRMOV || icode == I_JXX) && !err)
      cnd = cond_eval(ifun, cc);
  end

`ifdef Y86_EXEC_HALT_EN
  logic halted;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (accept && icode == I_HALT)
      halted <= 1'b1;
  end
  assign in_ready = (!out_valid || out_ready) && !halted;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign accept = in_valid && in_ready;
  assign cc_upd = accept && icode == I_OPQ && !err;

  // Stage boundary: execute -> memory output register and condition codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
      cc        <= 3'b100;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_icode <= icode;
        out_valE  <= err ? '0 : unsigned'(vale);
        out_valA  <= valA;
        out_cnd   <= cnd;
        out_err   <= err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cc_upd)
        cc <= {alu_e == '0, alu_e[W-1], of_n};
    end
  end
endmodule

// File: tb/tb_y86_execute_cc.sv
// Randomized and directed bench for y86_execute_cc against a wide-arithmetic reference model.
module tb_y86_execute_cc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_cnd, out_err;
  logic [3:0]  icode, ifun, out_icode;
  logic [63:0] valA, valB, valC, out_valE, out_valA;
  logic [2:0]  cc;

  int n_chk = 0, n_pass = 0;

  // reference state
  logic        m_valid, m_cnd, m_err, m_halted, last_acc;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valA;
  logic [2:0]  m_cc;

  y86_execute_cc #(.W(64), .STACK_STEP(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .out_valA(out_valA), .out_cnd(out_cnd),
    .out_err(out_err), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_icode = '0; m_valE = '0; m_valA = '0;
    m_cnd = 1'b0; m_err = 1'b0; m_cc = 3'b100; m_halted = 1'b0;
  endtask

  task automatic ref_exec(input logic [3:0] ic, input logic [3:0] ifn,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [2:0] ccin, output logic [63:0] e, output logic cnd,
                          output logic err, output logic [2:0] ccn);
    logic signed [64:0] wide;
    logic zf, lt, ovf;
    zf  = ccin[2];
    lt  = ccin[1] ^ ccin[0];
    err = (ic > 4'hB) || (ic == 4'h6 && ifn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && ifn > 4'd6);
    ccn = ccin;
    e   = '0;
    cnd = 1'b0;
    case (ic)
      4'h2: e = a;
      4'h3: e = c;
      4'h4, 4'h5: e = b + c;
      4'h6: begin
        ovf = 1'b0;
        if (ifn == 4'd0 || ifn == 4'd1) begin
          wide = (ifn == 4'd0) ? $signed({b[63], b}) + $signed({a[63], a})
                               : $signed({b[63], b}) - $signed({a[63], a});
          e   = wide[63:0];
          ovf = wide[64] != wide[63];
        end else begin
          e = (ifn == 4'd2) ? (b & a) : (b ^ a);
        end
        if (!err) ccn = {e == 64'd0, e[63], ovf};
      end
      4'h8, 4'hA: e = b - 64'd8;
      4'h9, 4'hB: e = b + 64'd8;
      default: e = '0;
    endcase
    if ((ic == 4'h2 || ic == 4'h7) && !err) begin
      case (ifn)
        4'd0: cnd = 1'b1;
        4'd1: cnd = lt | zf;
        4'd2: cnd = lt;
        4'd3: cnd = zf;
        4'd4: cnd = !zf;
        4'd5: cnd = !lt;
        default: cnd = !lt && !zf;
      endcase
    end
    if (err) e = '0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({pfx, "out_icode"}, 64'(out_icode), 64'(m_icode));
    chk({pfx, "out_valE"}, out_valE, m_valE);
    chk({pfx, "out_valA"}, out_valA, m_valA);
    chk({pfx, "out_cnd"}, 64'(out_cnd), 64'(m_cnd));
    chk({pfx, "out_err"}, 64'(out_err), 64'(m_err));
    chk({pfx, "cc"}, 64'(cc), 64'(m_cc));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks the result after the next edge.
  task automatic cycle(input logic iv, input logic [3:0] ic, input logic [3:0] ifn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic ordy);
    logic exp_ready, cnd, err;
    logic [63:0] e;
    logic [2:0] ccn;
    in_valid = iv; icode = ic; ifun = ifn; valA = a; valB = b; valC = c; out_ready = ordy;
    #1;
    exp_ready = (!m_valid || ordy) && !m_halted;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    @(posedge clk);
    last_acc = iv && exp_ready;
    if (last_acc) begin
      ref_exec(ic, ifn, a, b, c, m_cc, e, cnd, err, ccn);
      m_valid = 1'b1; m_icode = ic; m_valE = e; m_valA = a; m_cnd = cnd; m_err = err; m_cc = ccn;
`ifdef Y86_EXEC_HALT_EN
      if (ic == 4'h0) m_halted = 1'b1;
`endif
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs("");
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, ordy);
  endtask

  // Result stalled at the output, then rst raised between clock edges.
  task automatic stall_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stall_valid", 64'(out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cc", 64'(cc), 64'h4);
    check_outputs("arst_");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return '1;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [3:0] pick_icode();
    logic [3:0] v;
    int k;
    k = $urandom_range(0, 9);
    if (k < 3) return 4'h6;
    if (k == 3) return 4'h7;
    if (k == 4) return 4'h2;
    v = 4'($urandom_range(0, 15));
`ifdef Y86_EXEC_HALT_EN
    if (v == 4'h0) v = 4'h1;
`endif
    return v;
  endfunction

  initial begin
    logic [2:0] cc_hold;
    logic hold, r_iv, r_or;
    logic [3:0] r_ic, r_if;
    logic [63:0] r_a, r_b, r_c;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; icode = '0; ifun = '0;
    valA = '0; valB = '0; valC = '0; last_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_");
    chk("reset_cc", 64'(cc), 64'h4);
    rst = 1'b0;

    // sub overflow, then jl
    cycle(1'b1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    chk("sub_valE", out_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_cc", 64'(cc), 64'h1);
    cycle(1'b1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 1'b1);
    chk("jl_cnd", 64'(out_cnd), 64'd1);
    // add, then cmovle
    cycle(1'b1, 4'h6, 4'h0, 64'd1, 64'd2147483647, 64'd0, 1'b1);
    chk("add_valE", out_valE, 64'd2147483648);
    chk("add_cc", 64'(cc), 64'h0);
    cycle(1'b1, 4'h2, 4'h1, 64'd5, 64'd6, 64'd0, 1'b1);
    chk("cmovle_cnd", 64'(out_cnd), 64'd0);
    // xor to zero, then je / jne
    cycle(1'b1, 4'h6, 4'h3, 64'd9, 64'd9, 64'd0, 1'b1);
    chk("xor_valE", out_valE, 64'd0);
    chk("xor_cc", 64'(cc), 64'h4);
    cycle(1'b1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("je_cnd", 64'(out_cnd), 64'd1);
    cycle(1'b1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("jne_cnd", 64'(out_cnd), 64'd0);

    // backpressure: pushq held for three cycles with subq waiting behind
    idle(1'b1);
    cycle(1'b1, 4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 1'b0);
    cc_hold = cc;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h6, 4'h1, 64'd3, 64'd10, 64'd0, 1'b0);
      chk("bp_valE", out_valE, 64'hF8);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_cc", 64'(cc), 64'(cc_hold));
    end
    cycle(1'b1, 4'h6, 4'h1, 64'd3, 64'd10, 64'd0, 1'b1);
    chk("bp_drain_sub", out_valE, 64'd7);
    idle(1'b1);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // illegal encodings
    cc_hold = cc;
    cycle(1'b1, 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1);
    chk("errC_err", 64'(out_err), 64'd1);
    chk("errC_valE", out_valE, 64'd0);
    chk("errC_cc", 64'(cc), 64'(cc_hold));
    cycle(1'b1, 4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 1'b1);
    chk("errop_err", 64'(out_err), 64'd1);
    chk("errop_cc", 64'(cc), 64'(cc_hold));

`ifdef Y86_EXEC_HALT_EN
    cycle(1'b1, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("halt_out", 64'(out_icode), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0);
      chk("halt_ready", 64'(in_ready), 64'd0);
    end
`else
    cycle(1'b1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 1'b1);
    cycle(1'b1, 4'h6, 4'h0, 64'd5, 64'd5, 64'd0, 1'b0);
`endif
    stall_reset();

    hold = 1'b0;
    r_iv = 1'b0; r_ic = '0; r_if = '0; r_a = '0; r_b = '0; r_c = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        r_iv = $urandom_range(0, 4) != 0;
        r_ic = pick_icode();
        r_if = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        r_a  = pick64();
        r_b  = ($urandom_range(0, 5) == 0) ? r_a : pick64();
        r_c  = pick64();
      end
      r_or = $urandom_range(0, 3) != 0;
      cycle(r_iv, r_ic, r_if, r_a, r_b, r_c, r_or);
      hold = r_iv && !last_acc;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/y86_execute_cc.md
# y86_execute_cc

Execute stage of the sequential Y86-64 datapath. Consumes decoded operands (icode, ifun, valA, valB, valC), computes valE with the 64-bit adder, subtractor (sub64x1), AND and XOR units, and maintains the condition-code register (ZF, SF, OF). Evaluates Cnd for jXX/cmovXX and presents registered results to the memory stage over a valid/ready handshake.

## Interface
- W, 64, datapath width; must equal the sub64x1 width.
- STACK_STEP, 8, stack-pointer adjustment for call/ret/pushq/popq.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept this cycle.
- icode  input  4  Y86 icode.
- ifun  input  4  Y86 ifun.
- valA, valB, valC  input  W each  operands from decode.
- out_valid  output  1  registered result valid.
- out_ready  input  1  memory stage accepts the result.
- out_icode  output  4  icode passed through.
- out_valE  output  W  execute result.
- out_valA  output  W  valA passed through, for the memory stage.
- out_cnd  output  1  condition outcome.
- out_err  output  1  illegal icode/ifun.
- cc  output  3  current {ZF,SF,OF}.

## Operation
- Single output register stage. in_ready = !out_valid || out_ready. Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- valE, by icode:
  - 2 (rrmovq/cmovXX): valA.
  - 3: valC.
  - 4/5: valB+valC.
  - 6 (OPq): valB op valA, with op 0=add, 1=sub (valB−valA via sub64x1), 2=and, 3=xor.
  - 8/A: valB−STACK_STEP.
  - 9/B: valB+STACK_STEP.
  - 0/1/7: valE=0.
- Arithmetic is two's complement modulo 2^W; no saturation.
- CC is updated only on an accepted OPq with legal ifun:
  - ZF = (valE==0); SF = valE[W−1].
  - add: OF = (A,B same sign) && (valE sign ≠ B sign).
  - sub: OF = (A,B signs differ) && (valE sign ≠ B sign).
  - and/xor: OF = 0.
- Cnd is evaluated only for icode 2 and 7. It uses the CC value held before the current instruction. Condition by ifun:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - For all other icodes, Cnd = 0.
- Illegal cases set out_err=1, out_valE=0 and leave CC unchanged:
  - icode > B;
  - OPq with ifun > 3;
  - icode 2/7 with ifun > 6.
- While stalled (out_valid && !out_ready), all out_* hold and CC holds.

## Timing
- Latency is 1 cycle, accept to out_valid.
- Throughput is 1 per cycle when out_ready is held high.
- CC changes on the same edge that captures the OPq result. The immediately following instruction sees the new CC.
- Simultaneous output drain and input accept in one cycle: the output register loads the new instruction with no bubble.
- Reset values:
  - out_valid=0, out_valE=0, out_valA=0, out_icode=0, out_cnd=0, out_err=0.
  - cc={ZF=1,SF=0,OF=0}.
- Reset asserted mid-stall discards the held result immediately, without waiting for a clock edge.
- in_valid while in_ready=0: inputs are ignored. Upstream must hold them stable.

## Configuration
- Macro: Y86_EXEC_HALT_EN.
- Defined:
  - An accepted halt (icode 0) sets a sticky halted flag.
  - From the next cycle, in_ready=0 until rst.
  - The halt itself still propagates to out_* normally.
- Undefined: halt behaves as nop and no halted flag exists.

## Test plan
- Reset, then sub with valB=64'h8000_0000_0000_0000, valA=1:
  - out_valE=64'h7FFF_FFFF_FFFF_FFFF; cc={0,0,1}.
  - A following jl (icode 7, ifun 2) gives out_cnd=1.
- add with valB=2147483647, valA=1:
  - out_valE=2147483648; cc={0,0,0}.
  - A following cmovle gives out_cnd=0.
- xor with valA=valB=9:
  - out_valE=0; cc={1,0,0}.
  - A following je gives out_cnd=1, and jne gives out_cnd=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with pushq valB=0x100 queued, then a subq behind it.
  - out_valE stays 0xF8, in_ready=0 and cc is unchanged until release.
  - After release, the results drain one per cycle.
- Error cases:
  - icode=C gives out_err=1, out_valE=0, cc unchanged.
  - OPq with ifun=5 gives out_err=1.
- Halt with Y86_EXEC_HALT_EN defined:
  - A halt followed by a nop leaves in_ready=0 permanently.
  - Asserting rst mid-stall clears out_valid in the same cycle and restores cc={1,0,0}.
